// File: rtl/alu_control.sv
// Lab ALU initiator: operand/opcode registers loaded from switches,
// button conditioning and a start/valid handshake sequencer.
module alu_control #(
   parameter int N       = 7,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  sw,
   input  logic [3:0]    btn,
   output logic [N-1:0]  alu_a,
   output logic [N-1:0]  alu_b,
   output logic [1:0]    alu_op,
   output logic          alu_start,
   input  logic [15:0]   alu_result,
   input  logic          alu_valid,
   output logic [15:0]   result_q,
   output logic          result_ready,
   output logic          busy,
   output logic          error,
   output logic [2:0]    state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   // Last WAIT cycle is the one whose incremented count hits LIM
   localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 1) ? TIMEOUT - 1 : 1);

   state_t        state_q, state_d;
   logic [3:0]    sync1_q, sync2_q, prev_q;
   logic [3:0]    edge_w;
   logic [N-1:0]  a_q, a_d, b_q, b_d;
   logic [1:0]    op_q, op_d;
   logic [15:0]   result_d;
   logic          rdy_q, rdy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N:0]    sw_x;
   logic          ld_w;

   assign sw_x   = {1'b0, sw};
   assign edge_w = sync2_q & ~prev_q;
   assign ld_w   = |edge_w[2:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         rdy_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= btn;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         rdy_q    <= rdy_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      rdy_d    = rdy_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (edge_w[0]) a_d = sw;
            if (edge_w[1]) b_d = sw;
            if (edge_w[2]) op_d = sw_x[1:0];
            if (ld_w) begin
               rdy_d = 1'b0;
            end else if (edge_w[3]) begin
               rdy_d   = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d = '0;
            if (alu_valid) begin
               result_d = alu_result;
               state_d  = S_DONE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (alu_valid) begin
               result_d = alu_result;
               state_d  = S_DONE;
            end else if (cnt_d == LIM) begin
               state_d = S_ERR;
            end
         end
         S_DONE: begin
            rdy_d   = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            rdy_d = 1'b0;
            if (|edge_w) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_op       = op_q;
   assign alu_start    = (state_q == S_START);
   assign busy         = (state_q == S_START) || (state_q == S_WAIT);
   assign error        = (state_q == S_ERR);
   assign result_ready = rdy_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_alu_control.sv
// Directed bench for alu_control with a behavioural ALU whose valid
// flag is under bench control.
module tb_alu_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  sw;
   logic [3:0]  btn;
   logic [6:0]  alu_a, alu_b;
   logic [1:0]  alu_op;
   logic        alu_start;
   logic [15:0] alu_result;
   logic        alu_valid;
   logic [15:0] result_q;
   logic        result_ready, busy, error;
   logic [2:0]  state_dbg;

   int total = 0;
   int passed = 0;
   int start_cnt = 0;
   int busy_cnt = 0;
   int s0, b0;

   always #5 clk = ~clk;

   alu_control #(.N(7), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_start(alu_start), .alu_result(alu_result),
      .alu_valid(alu_valid), .result_q(result_q),
      .result_ready(result_ready), .busy(busy),
      .error(error), .state_dbg(state_dbg)
   );

   logic        valid_en;
   logic [15:0] a16, b16;
   assign a16 = {9'd0, alu_a};
   assign b16 = {9'd0, alu_b};
   assign alu_valid = valid_en;

   always_comb begin
      alu_result = 16'h0;
      case (alu_op)
         2'd0: alu_result = a16 & b16;
         2'd1: alu_result = a16 | b16;
         2'd2: alu_result = a16 + b16;
         default: alu_result = a16 - b16;
      endcase
   end

   always @(negedge clk) begin
      if (alu_start) start_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int i, input logic [6:0] v);
      sw = v;
      btn[i] = 1'b1;
      tick(1);
      btn[i] = 1'b0;
      tick(5);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      s0 = start_cnt;
      tick(10);
      total++;
      if (alu_a !== 7'd0) $display("FAIL rst_a got %h exp 0", alu_a);
      else passed++;
      total++;
      if (alu_b !== 7'd0) $display("FAIL rst_b got %h exp 0", alu_b);
      else passed++;
      total++;
      if (alu_op !== 2'd0) $display("FAIL rst_op got %h exp 0", alu_op);
      else passed++;
      total++;
      if (result_q !== 16'h0) $display("FAIL rst_res got %h exp 0", result_q);
      else passed++;
      total++;
      if ({result_ready, busy, error, alu_start} !== 4'b0)
         $display("FAIL rst_flags got %b exp 0000",
                  {result_ready, busy, error, alu_start});
      else passed++;
      total++;
      if (state_dbg !== 3'd0) $display("FAIL rst_state got %0d exp 0", state_dbg);
      else passed++;
      total++;
      if (start_cnt - s0 !== 0) $display("FAIL rst_start got %0d exp 0", start_cnt - s0);
      else passed++;
   endtask

   task automatic test_add;
      valid_en = 1'b1;
      press(0, 7'd5);
      press(1, 7'd3);
      press(2, 7'd2);
      s0 = start_cnt;
      b0 = busy_cnt;
      press(3, 7'd0);
      total++;
      if (start_cnt - s0 !== 1) $display("FAIL add_start got %0d exp 1", start_cnt - s0);
      else passed++;
      total++;
      if (busy_cnt - b0 !== 1) $display("FAIL add_busy got %0d exp 1", busy_cnt - b0);
      else passed++;
      total++;
      if (result_q !== 16'h0008) $display("FAIL add_res got %h exp 0008", result_q);
      else passed++;
      total++;
      if (result_ready !== 1'b1) $display("FAIL add_rdy got %b exp 1", result_ready);
      else passed++;
      total++;
      if (state_dbg !== 3'd0) $display("FAIL add_state got %0d exp 0", state_dbg);
      else passed++;
   endtask

   task automatic test_sub_and;
      press(0, 7'd3);
      total++;
      if (result_ready !== 1'b0) $display("FAIL ld_clr got %b exp 0", result_ready);
      else passed++;
      press(1, 7'd5);
      press(2, 7'd3);
      press(3, 7'd0);
      total++;
      if (result_q !== 16'hFFFE) $display("FAIL sub_res got %h exp fffe", result_q);
      else passed++;
      total++;
      if (result_ready !== 1'b1) $display("FAIL sub_rdy got %b exp 1", result_ready);
      else passed++;
      press(2, 7'd0);
      total++;
      if (result_ready !== 1'b0) $display("FAIL op_clr got %b exp 0", result_ready);
      else passed++;
      press(0, 7'h55);
      press(1, 7'h0F);
      press(3, 7'd0);
      total++;
      if (result_q !== 16'h0005) $display("FAIL and_res got %h exp 0005", result_q);
      else passed++;
   endtask

   task automatic test_timeout;
      int n;
      valid_en = 1'b0;
      b0 = busy_cnt;
      sw = 7'd0;
      btn[3] = 1'b1;
      tick(1);
      btn[3] = 1'b0;
      n = 0;
      while (state_dbg !== 3'd4 && n < 40) begin
         tick(1);
         n++;
      end
      total++;
      if (state_dbg !== 3'd4) $display("FAIL to_state got %0d exp 4", state_dbg);
      else passed++;
      tick(2);
      total++;
      if (busy_cnt - b0 !== 16) $display("FAIL to_busy got %0d exp 16", busy_cnt - b0);
      else passed++;
      total++;
      if (error !== 1'b1) $display("FAIL to_err got %b exp 1", error);
      else passed++;
      total++;
      if (result_q !== 16'h0005) $display("FAIL to_res got %h exp 0005", result_q);
      else passed++;
      press(1, 7'h7F);
      total++;
      if ({error, state_dbg} !== 4'b0000)
         $display("FAIL err_clr got %b exp 0000", {error, state_dbg});
      else passed++;
      total++;
      if ({alu_a, alu_b} !== {7'h55, 7'h0F})
         $display("FAIL err_ops got %h exp %h", {alu_a, alu_b}, {7'h55, 7'h0F});
      else passed++;
   endtask

   task automatic test_busy_load;
      valid_en = 1'b0;
      sw = 7'd0;
      btn[3] = 1'b1;
      tick(1);
      btn[3] = 1'b0;
      tick(4);
      total++;
      if (state_dbg !== 3'd2) $display("FAIL bl_wait got %0d exp 2", state_dbg);
      else passed++;
      press(0, 7'd9);
      valid_en = 1'b1;
      tick(4);
      total++;
      if (alu_a !== 7'h55) $display("FAIL bl_a got %h exp 55", alu_a);
      else passed++;
      total++;
      if (result_q !== 16'h0005) $display("FAIL bl_res got %h exp 0005", result_q);
      else passed++;
      total++;
      if (result_ready !== 1'b1) $display("FAIL bl_rdy got %b exp 1", result_ready);
      else passed++;
      s0 = start_cnt;
      sw = 7'h11;
      btn = 4'b1001;
      tick(1);
      btn = 4'b0000;
      tick(6);
      total++;
      if (alu_a !== 7'h11) $display("FAIL sim_a got %h exp 11", alu_a);
      else passed++;
      total++;
      if (start_cnt - s0 !== 0) $display("FAIL sim_start got %0d exp 0", start_cnt - s0);
      else passed++;
      total++;
      if (result_ready !== 1'b0) $display("FAIL sim_rdy got %b exp 0", result_ready);
      else passed++;
   endtask

   task automatic test_reset_wait;
      valid_en = 1'b0;
      sw = 7'd0;
      btn[3] = 1'b1;
      tick(1);
      btn[3] = 1'b0;
      tick(4);
      total++;
      if (state_dbg !== 3'd2) $display("FAIL rw_wait got %0d exp 2", state_dbg);
      else passed++;
      rst_n = 1'b0;
      tick(1);
      total++;
      if ({state_dbg, busy} !== 4'b0000)
         $display("FAIL rw_idle got %b exp 0000", {state_dbg, busy});
      else passed++;
      total++;
      if (result_q !== 16'h0) $display("FAIL rw_res0 got %h exp 0", result_q);
      else passed++;
      rst_n = 1'b1;
      valid_en = 1'b1;
      s0 = start_cnt;
      tick(5);
      total++;
      if ({result_q, result_ready} !== 17'h0)
         $display("FAIL rw_nocap got %h exp 0", {result_q, result_ready});
      else passed++;
      total++;
      if (start_cnt - s0 !== 0) $display("FAIL rw_start got %0d exp 0", start_cnt - s0);
      else passed++;
   endtask

   initial begin
      rst_n = 1'b0;
      sw = 7'd0;
      btn = 4'd0;
      valid_en = 1'b0;
      test_reset;
      test_add;
      test_sub_and;
      test_timeout;
      test_busy_load;
      test_reset_wait;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
